fetch_unit: RTL and testbench
=============================

# fetch_unit

IF-stage PC generator and I-cache request sequencer, directly upstream of the hazard controller. It consumes the controller's `i2i_hc` stall and `load_pc` redirect. It issues one I-cache request per cycle, tracks the in-flight request, re-issues on miss, and holds a delivered instruction while IF is stalled. It presents `{pc, instr, valid}` to the IF/DEC pipeline register.

## Interface
Parameters:
- `RESET_PC`, default `32'h0040_0000`: first fetch address after reset.
- `PC_INCR`, default `4`: sequential increment, in bytes.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `i2i_hc`, `hazard_control_ifc.in`, –: only `.stall` is used; `.flush` is ignored.
- `load_pc`, `load_pc_ifc.in`, –: `.we` and `.new_pc` (`ADDR_WIDTH`) carry the redirect.
- `ic_req_valid`, out, 1: I-cache request strobe.
- `ic_req_addr`, out, `ADDR_WIDTH`: I-cache request address.
- `ic_rsp_valid`, in, 1: response for the request of the previous cycle; 0 means miss.
- `ic_rsp_data`, in, `DATA_WIDTH`: instruction word.
- `if_valid`, out, 1: instruction available to IF/DEC.
- `if_pc`, out, `ADDR_WIDTH`: PC of the presented instruction.
- `if_instr`, out, `DATA_WIDTH`: the presented instruction.
- `perf_fetched`, out, 32: instructions accepted by IF/DEC.
- `perf_redirects`, out, 32: cycles with `load_pc.we`.
- `perf_miss_cycles`, out, 32: cycles with a live miss.

## Operation
FSM `fetch_state_t`, two states:
- `BOOT` → `RUN` unconditionally after one cycle.
- `RUN` persists until reset.

Registers:
- `pc_q`: next sequential request address.
- `req_pc_q`, `req_live_q`: the request in flight.
- `hold_valid_q`, `hold_pc_q`, `hold_instr_q`: the held instruction.

Combinational terms:
- `miss = req_live_q & ~ic_rsp_valid`
- `deliver = req_live_q & ic_rsp_valid`

Request issue:
- In `BOOT`, `ic_req_valid` = 0.
- In `RUN`, `ic_req_valid` = 1 and `ic_req_addr = miss ? req_pc_q : pc_q`.

Next-state update, in priority order:
1. `load_pc.we`: `pc_q <= new_pc`; `req_live_q <= 0`. This kills the request issued this cycle; a miss retry is abandoned.
2. `miss`: `pc_q` holds; `req_pc_q` holds; `req_live_q <= 1`, so the retry is live.
3. `i2i_hc.stall`: `pc_q` holds; `req_live_q <= 0`. The same address is re-issued next cycle.
4. Otherwise: `req_pc_q <= pc_q`; `pc_q <= pc_q + PC_INCR` (modulo 2^`ADDR_WIDTH`, wraps silently); `req_live_q <= 1`.

Output selection:
- `if_valid = hold_valid_q | deliver`.
- `if_pc` and `if_instr` come from the hold registers when `hold_valid_q` = 1, otherwise from `req_pc_q` and `ic_rsp_data`.
- When `if_valid` = 0, `if_pc` and `if_instr` are don't-care but must be driven.

Hold buffer:
- Set when `deliver & i2i_hc.stall & ~hold_valid_q`.
- Cleared on the first cycle with `~i2i_hc.stall`.
- `load_pc.we` does not clear it, so a delay-slot instruction survives a redirect during a DEC stall.

Responses:
- `ic_rsp_valid` is ignored whenever `req_live_q` = 0.

Simultaneous events:
- Redirect plus miss: the redirect wins.
- Redirect plus stall: the redirect wins; `pc_q` is updated while stalled.
- Miss plus `hold_valid_q`: cannot occur, because a miss asserts stall and no new live request exists. An assertion flags it.

## Timing
Reset values:
- FSM state `BOOT`.
- `pc_q` = `RESET_PC`.
- `req_live_q` = 0, `hold_valid_q` = 0.
- `ic_req_valid` = 0, `if_valid` = 0.
- Perf counters = 0.

Reset asserted mid-operation:
- All state returns to the values above on the next edge.
- Any in-flight response is ignored.

Startup sequence, with cycle 0 being the first edge at which `rst_n` is sampled high:
- Cycle 0: `BOOT`.
- Cycle 1: request `RESET_PC`.
- Cycle 2: earliest `if_valid`.

Latency and throughput:
- Request-to-`if_valid` latency is 1 cycle on a hit.
- Throughput is 1 instruction per cycle with no stall.
- A redirect asserted in cycle N produces a request to `new_pc` in cycle N+1 and data in N+2.

## Configuration
`FETCH_PERF_EN`:
- Defined: the three counters are implemented, each saturating at `32'hFFFF_FFFF`.
  - `perf_fetched` increments on `if_valid & ~i2i_hc.stall`.
  - `perf_redirects` increments on `load_pc.we`.
  - `perf_miss_cycles` increments on `miss`.
- Undefined: the counter ports remain present and are tied to 0; no counter flops are instantiated.

## Structure
- `fetch_state_t` (`BOOT`, `RUN`) goes in `mips_core_pkg`.
- `ADDR_WIDTH` and `DATA_WIDTH` come from `mips_core.svh`.
- One sub-module, `fetch_perf_counter`: a 32-bit saturating counter with an increment enable. It is instantiated three times under `FETCH_PERF_EN`.

## Test plan
- **Reset release:** `RESET_PC = 32'h0040_0000`, all hits → requests 0x400000, 0x400004, 0x400008; `if_valid` first high in cycle 2 with `if_pc` = 0x400000.
- **Miss:** miss on 0x400004 for 3 cycles with stall asserted → `ic_req_addr` = 0x400004 for 3 cycles; no `if_valid`; then 0x400004 delivered and 0x400008 requested; `perf_miss_cycles` = 3.
- **DEC stall:** 2-cycle stall while 0x400008 is delivered → `if_pc`/`if_instr` stable at 0x400008 both cycles; `ic_req_addr` = 0x40000C repeated; after release, the next instruction is 0x40000C with no duplicate and no drop.
- **Redirect:** `load_pc.we`, `new_pc` = 0x400100 in cycle N → the N+1 response is ignored; request 0x400100 in N+1; `if_pc` = 0x400100 in N+2; `perf_redirects` = 1.
- **Redirect during a held stall:** redirect while `hold_valid_q` = 1 → held instruction is still presented until the stall drops, followed by the `new_pc` stream.
- **Wrap-around:** redirect to 0xFFFFFFFC → next request is 0x00000000.

Source files
------------

// File: rtl/mips_core_pkg.sv
// Shared types and widths for the MIPS core front end.
`include "mips_core.svh"

package mips_core_pkg;
    localparam int ADDR_WIDTH = `ADDR_WIDTH;
    localparam int DATA_WIDTH = `DATA_WIDTH;

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/hazard_control_ifc.sv
// Stall/flush bundle driven by the hazard controller into each stage.
interface hazard_control_ifc;
    logic stall;
    logic flush;

    modport in  (input stall, input flush);
    modport out (output stall, output flush);
endinterface

// File: rtl/load_pc_ifc.sv
// Control-flow redirect bundle carrying a write enable and the target PC.
interface load_pc_ifc;
    import mips_core_pkg::*;

    logic                  we;
    logic [ADDR_WIDTH-1:0] new_pc;

    modport in  (input we, input new_pc);
    modport out (output we, output new_pc);
endinterface

// File: rtl/fetch_perf_counter.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module fetch_perf_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [31:0] count
);
    // Saturating increment on each enabled cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= 32'd0;
        end else if (inc && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end else begin
            count <= count;
        end
    end
endmodule

// File: rtl/fetch_unit_checker.sv
// Invariant checks for fetch_unit, kept apart from the datapath.
module fetch_unit_checker (
    input logic clk,
    input logic rst_n,
    input logic miss,
    input logic hold_valid
);
    // A live miss implies the stage was not stalled holding an instruction
    assert property (@(posedge clk) disable iff (!rst_n) !(miss && hold_valid));
endmodule

// File: rtl/mips_core.svh
// Core-wide datapath widths shared by every pipeline stage.
`ifndef MIPS_CORE_SVH
`define MIPS_CORE_SVH
`define ADDR_WIDTH 32
`define DATA_WIDTH 32
`endif

// File: rtl/fetch_unit.sv
// IF-stage PC generator and I-cache request sequencer with a one-entry hold buffer.
// Define FETCH_PERF_EN to build the saturating performance counters.
module fetch_unit
    import mips_core_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h0040_0000,
    parameter logic [ADDR_WIDTH-1:0] PC_INCR  = 32'd4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hazard_control_ifc.in         i2i_hc,
    load_pc_ifc.in                load_pc,
    output logic                  ic_req_valid,
    output logic [ADDR_WIDTH-1:0] ic_req_addr,
    input  logic                  ic_rsp_valid,
    input  logic [DATA_WIDTH-1:0] ic_rsp_data,
    output logic                  if_valid,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic [DATA_WIDTH-1:0] if_instr,
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_redirects,
    output logic [31:0]           perf_miss_cycles
);
    fetch_state_t          state_r;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] req_pc_q;
    logic                  req_live_q;
    logic                  hold_valid_q;
    logic [ADDR_WIDTH-1:0] hold_pc_q;
    logic [DATA_WIDTH-1:0] hold_instr_q;
    logic                  stall_s;
    logic                  miss_s;
    logic                  deliver_s;

    assign stall_s   = i2i_hc.stall;
    assign miss_s    = req_live_q & ~ic_rsp_valid;
    assign deliver_s = req_live_q & ic_rsp_valid;

    // Request steering and IF/DEC presentation
    always_comb begin
        ic_req_valid = 1'b0;
        ic_req_addr  = pc_q;
        if (state_r == RUN) begin
            ic_req_valid = 1'b1;
            ic_req_addr  = miss_s ? req_pc_q : pc_q;
        end else begin
            ic_req_valid = 1'b0;
            ic_req_addr  = pc_q;
        end
        if_valid = hold_valid_q | deliver_s;
        if (hold_valid_q) begin
            if_pc    = hold_pc_q;
            if_instr = hold_instr_q;
        end else begin
            if_pc    = req_pc_q;
            if_instr = ic_rsp_data;
        end
    end

    // FSM plus fetch pointer and in-flight request tracking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= BOOT;
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            req_live_q <= 1'b0;
        end else begin
            case (state_r)
                BOOT: begin
                    state_r <= RUN;
                end
                RUN: begin
                    state_r <= RUN;
                    // Redirect outranks a pending retry; a stall just drops this cycle's request
                    if (load_pc.we) begin
                        pc_q       <= load_pc.new_pc;
                        req_live_q <= 1'b0;
                    end else if (miss_s) begin
                        req_live_q <= 1'b1;
                    end else if (stall_s) begin
                        req_live_q <= 1'b0;
                    end else begin
                        req_pc_q   <= pc_q;
                        pc_q       <= pc_q + PC_INCR;
                        req_live_q <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= BOOT;
                    req_live_q <= 1'b0;
                end
            endcase
        end
    end

    // Hold buffer keeps a delivered word alive across a DEC stall, even through a redirect
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_valid_q <= 1'b0;
            hold_pc_q    <= {ADDR_WIDTH{1'b0}};
            hold_instr_q <= {DATA_WIDTH{1'b0}};
        end else if (!stall_s) begin
            hold_valid_q <= 1'b0;
        end else if (deliver_s && !hold_valid_q) begin
            hold_valid_q <= 1'b1;
            hold_pc_q    <= req_pc_q;
            hold_instr_q <= ic_rsp_data;
        end else begin
            hold_valid_q <= hold_valid_q;
        end
    end

`ifdef FETCH_PERF_EN
    fetch_perf_counter u_perf_fetched (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (if_valid & ~stall_s),
        .count (perf_fetched)
    );
    fetch_perf_counter u_perf_redirects (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (load_pc.we),
        .count (perf_redirects)
    );
    fetch_perf_counter u_perf_miss (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (miss_s),
        .count (perf_miss_cycles)
    );
`else
    assign perf_fetched     = 32'd0;
    assign perf_redirects   = 32'd0;
    assign perf_miss_cycles = 32'd0;
`endif

    fetch_unit_checker u_checker (
        .clk        (clk),
        .rst_n      (rst_n),
        .miss       (miss_s),
        .hold_valid (hold_valid_q)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then randomized traffic against a queue model.
module tb_fetch_unit;
    import mips_core_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ic_req_valid;
    logic [31:0] ic_req_addr;
    logic        ic_rsp_valid;
    logic [31:0] ic_rsp_data;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] perf_fetched;
    logic [31:0] perf_redirects;
    logic [31:0] perf_miss_cycles;

    hazard_control_ifc hc ();
    load_pc_ifc        lp ();

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC), .PC_INCR(32'd4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i2i_hc           (hc),
        .load_pc          (lp),
        .ic_req_valid     (ic_req_valid),
        .ic_req_addr      (ic_req_addr),
        .ic_rsp_valid     (ic_rsp_valid),
        .ic_rsp_data      (ic_rsp_data),
        .if_valid         (if_valid),
        .if_pc            (if_pc),
        .if_instr         (if_instr),
        .perf_fetched     (perf_fetched),
        .perf_redirects   (perf_redirects),
        .perf_miss_cycles (perf_miss_cycles)
    );

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // Reference model: the fetch pointer, at most one live request, at most one held PC
    bit          m_boot;
    logic [31:0] m_next;
    logic [31:0] m_fly[$];
    logic [31:0] m_held[$];
    logic [31:0] m_fetched, m_redir, m_misses;
    logic [31:0] prev_req;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] perf_exp(input logic [31:0] v);
`ifdef FETCH_PERF_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_edge();
        logic live, miss, got, ifv;
        if (!rst_n) begin
            m_boot = 1'b1;
            m_next = RST_PC;
            m_fly.delete();
            m_held.delete();
            m_fetched = 32'd0;
            m_redir   = 32'd0;
            m_misses  = 32'd0;
            return;
        end
        live = (m_fly.size() != 0);
        miss = live && !ic_rsp_valid;
        got  = live && ic_rsp_valid;
        ifv  = (m_held.size() != 0) || got;
        if (ifv && !hc.stall) m_fetched = sat_inc(m_fetched);
        if (lp.we)            m_redir   = sat_inc(m_redir);
        if (miss)             m_misses  = sat_inc(m_misses);
        if (m_boot) begin
            m_boot = 1'b0;
            return;
        end
        if (!hc.stall) m_held.delete();
        else if (got && m_held.size() == 0) m_held.push_back(m_fly[0]);
        if (lp.we) begin
            m_next = lp.new_pc;
            m_fly.delete();
        end else if (miss) begin
            m_next = m_next;
        end else if (hc.stall) begin
            m_fly.delete();
        end else begin
            m_fly.delete();
            m_fly.push_back(m_next);
            m_next = m_next + 32'd4;
        end
    endtask

    task automatic compare_outputs();
        logic        live, miss, got, ifv;
        logic [31:0] e_addr, e_pc;
        live   = (m_fly.size() != 0);
        miss   = live && !ic_rsp_valid;
        got    = live && ic_rsp_valid;
        ifv    = (m_held.size() != 0) || got;
        e_addr = m_next;
        if (miss) e_addr = m_fly[0];
        check_eq("req_valid", 32'(ic_req_valid), 32'(!m_boot));
        if (!m_boot) check_eq("req_addr", ic_req_addr, e_addr);
        check_eq("if_valid", 32'(if_valid), 32'(ifv));
        if (ifv) begin
            e_pc = (m_held.size() != 0) ? m_held[0] : m_fly[0];
            check_eq("if_pc", if_pc, e_pc);
            check_eq("if_instr", if_instr, mem(e_pc));
        end
        check_eq("perf_fetched", perf_fetched, perf_exp(m_fetched));
        check_eq("perf_redirects", perf_redirects, perf_exp(m_redir));
        check_eq("perf_miss_cycles", perf_miss_cycles, perf_exp(m_misses));
        prev_req = e_addr;
    endtask

    task automatic step(input logic st, input logic we, input logic [31:0] npc, input logic hit);
        @(posedge clk);
        model_edge();
        #1;
        hc.stall     = st;
        hc.flush     = 1'($urandom);
        lp.we        = m_boot ? 1'b0 : we;
        lp.new_pc    = npc;
        ic_rsp_valid = hit;
        ic_rsp_data  = hit ? mem(prev_req) : $urandom;
        @(negedge clk);
        compare_outputs();
    endtask

    initial begin
        logic [31:0] npc;
        rst_n        = 1'b0;
        hc.stall     = 1'b0;
        hc.flush     = 1'b0;
        lp.we        = 1'b0;
        lp.new_pc    = 32'd0;
        ic_rsp_valid = 1'b0;
        ic_rsp_data  = 32'd0;
        prev_req     = 32'd0;

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 1'b1);
        check_eq("boot_req_valid", 32'(ic_req_valid), 32'd0);
        check_eq("boot_if_valid", 32'(if_valid), 32'd0);
        rst_n = 1'b1;

        // Reset release: first request at RESET_PC, first instruction a cycle later
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check_eq("c1_req_valid", 32'(ic_req_valid), 32'd1);
        check_eq("c1_req_addr", ic_req_addr, 32'h0040_0000);
        check_eq("c1_if_valid", 32'(if_valid), 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check_eq("c2_if_pc", if_pc, 32'h0040_0000);
        check_eq("c2_req_addr", ic_req_addr, 32'h0040_0004);

        // Three-cycle miss on 0x400004 under stall
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'd0, 1'b0);
            check_eq("miss_req_addr", ic_req_addr, 32'h0040_0004);
            check_eq("miss_if_valid", 32'(if_valid), 32'd0);
        end
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check_eq("miss_done_pc", if_pc, 32'h0040_0004);
        check_eq("miss_done_req", ic_req_addr, 32'h0040_0008);
        check_eq("miss_count", perf_miss_cycles, perf_exp(32'd3));

        // Two-cycle DEC stall while 0x400008 is delivered
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 32'd0, 1'b1);
            check_eq("stall_if_pc", if_pc, 32'h0040_0008);
            check_eq("stall_if_instr", if_instr, mem(32'h0040_0008));
            check_eq("stall_req_addr", ic_req_addr, 32'h0040_000C);
        end
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check_eq("release_pc", if_pc, 32'h0040_0008);

        // Redirect to 0x400100; the response right after it is stale
        step(1'b0, 1'b1, 32'h0040_0100, 1'b1);
        check_eq("pre_redir_pc", if_pc, 32'h0040_000C);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check_eq("redir_n1_valid", 32'(if_valid), 32'd0);
        check_eq("redir_n1_req", ic_req_addr, 32'h0040_0100);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        check_eq("redir_n2_pc", if_pc, 32'h0040_0100);
        check_eq("redir_count", perf_redirects, perf_exp(32'd1));

        // Redirect while a stalled instruction is held
        step(1'b1, 1'b1, 32'h0040_0200, 1'b1);
        check_eq("held_redir_pc", if_pc, 32'h0040_0100);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        check_eq("held_after_pc", if_pc, 32'h0040_0100);
        check_eq("held_after_req", ic_req_addr, 32'h0040_0200);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check_eq("held_release_pc", if_pc, 32'h0040_0100);

        // Wrap-around past the top of the address space
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        check_eq("new_stream_pc", if_pc, 32'h0040_0200);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check_eq("wrap_req_top", ic_req_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check_eq("wrap_req_zero", ic_req_addr, 32'h0000_0000);
        check_eq("wrap_if_pc", if_pc, 32'hFFFF_FFFC);

        // Randomized traffic with occasional mid-run resets
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            npc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'h0000_000C))
                                              : ($urandom & 32'hFFFF_FFFC);
            step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 11) == 0),
                 npc, 1'($urandom_range(0, 4) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
